// File: rtl/snake_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : snake_pkg
// Purpose  : Shared types for the snake direction controller: direction
//            encoding, 2-bit direction type, controller FSM states and the
//            opposite-direction helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package snake_pkg;

    typedef logic [1:0] dir_t;

    // Encoding pairs opposite directions so they differ only in bit 0.
    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic dir_t opposite_dir(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dir_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dir_fifo
// Purpose  : Small synchronous FIFO of directions holding pending turns.
//            Exposes both head (next to apply) and tail (last queued) so the
//            controller can filter new turns against the most recent one.
// Ports    : clk, reset (sync, active-low), flush, push, push_dir, pop,
//            head, tail, full, empty, count
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dir_fifo
    import snake_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  dir_t                           push_dir,
    input  logic                           pop,
    output dir_t                           head,
    output dir_t                           tail,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    dir_t                 r_mem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_do_push;
    logic                 w_do_pop;
    logic [c_PTR_W-1:0]   w_tail_ptr;

    assign full       = (r_count == c_CNT_W'(QUEUE_DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign w_tail_ptr = r_wr_ptr - 1'b1;
    assign head       = r_mem[r_rd_ptr];
    assign tail       = r_mem[w_tail_ptr];

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointers are power-of-two wide, so wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= push_dir;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : snake_dir_ctrl
// Purpose  : Converts key-press pulses into the snake movement direction.
//            Queues up to QUEUE_DEPTH turns, applies one per move_tick, and
//            rejects no-op and reversal turns.
// Ports    : clk, reset (sync, active-low)
//            up/down/left/right_press - one-cycle key pulses
//            game_run   - level, game in progress
//            move_tick  - one-cycle pulse, snake advances
//            cur_dir    - applied direction (UP=0 DOWN=1 LEFT=2 RIGHT=3)
//            dir_changed- pulse, cur_dir updated
//            queue_count- pending turns
//            drop_pulse - pulse, press discarded (queue full)
//            drop_count - saturating drop counter (SNAKE_DIR_DROP_STATS_EN)
// Config   : define SNAKE_DIR_DROP_STATS_EN to add drop_count[7:0].
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int   QUEUE_DEPTH = 4,
    parameter dir_t INIT_DIR    = DIR_RIGHT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           up_press,
    input  logic                           down_press,
    input  logic                           left_press,
    input  logic                           right_press,
    input  logic                           game_run,
    input  logic                           move_tick,
    output dir_t                           cur_dir,
    output logic                           dir_changed,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
`ifdef SNAKE_DIR_DROP_STATS_EN
    output logic [7:0]                     drop_count,
`endif
    output logic                           drop_pulse
);

    state_t  r_state;
    dir_t    r_cur_dir;
    logic    r_dir_changed;
    logic    r_drop_pulse;

    state_t  w_state_nxt;
    dir_t    w_cur_dir_nxt;
    logic    w_dir_changed_nxt;
    logic    w_drop_nxt;
    logic    w_flush;
    logic    w_push;
    logic    w_pop;

    logic    w_cand_valid;
    dir_t    w_cand;
    dir_t    w_ref;
    logic    w_accept;
    logic    w_can_pop;

    dir_t    w_head;
    dir_t    w_tail;
    logic    w_full;
    logic    w_empty;
    logic [$clog2(QUEUE_DEPTH):0] w_count;

    dir_fifo #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .push     (w_push),
        .push_dir (w_cand),
        .pop      (w_pop),
        .head     (w_head),
        .tail     (w_tail),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    // Fixed priority up > down > left > right; losers are silently ignored.
    assign w_cand_valid = up_press | down_press | left_press | right_press;
    assign w_cand = up_press   ? DIR_UP   :
                    down_press ? DIR_DOWN :
                    left_press ? DIR_LEFT : DIR_RIGHT;

    // Filter against the last queued turn, not the applied one, so a burst
    // of quick presses cannot sneak in a reversal. Uses pre-pop queue state.
    assign w_ref    = w_empty ? r_cur_dir : w_tail;
    assign w_accept = w_cand_valid && (w_cand != w_ref) &&
                      (w_cand != opposite_dir(w_ref));
    assign w_can_pop = move_tick && !w_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cur_dir     <= INIT_DIR;
            r_dir_changed <= 1'b0;
            r_drop_pulse  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_dir     <= w_cur_dir_nxt;
            r_dir_changed <= w_dir_changed_nxt;
            r_drop_pulse  <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cur_dir_nxt     = r_cur_dir;
        w_dir_changed_nxt = 1'b0;
        w_drop_nxt        = 1'b0;
        w_flush           = 1'b0;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (game_run) begin
                    w_state_nxt   = ST_RUN;
                    w_cur_dir_nxt = INIT_DIR;
                    w_flush       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!game_run) begin
                    // Leaving the game wins over any same-cycle push or pop.
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else begin
                    if (w_can_pop) begin
                        w_pop             = 1'b1;
                        w_cur_dir_nxt     = w_head;
                        w_dir_changed_nxt = 1'b1;
                    end
                    if (w_accept) begin
                        if (!w_full || w_can_pop) begin
                            w_push = 1'b1;
                        end else begin
                            w_drop_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef SNAKE_DIR_DROP_STATS_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (!reset || (r_state == ST_IDLE && game_run)) begin
            r_drop_count <= 8'd0;
        end else if (w_drop_nxt && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign cur_dir     = r_cur_dir;
    assign dir_changed = r_dir_changed;
    assign drop_pulse  = r_drop_pulse;
    assign queue_count = w_count;

endmodule
`default_nettype wire
